boot_loader: RTL

Parametrised program-load controller that sits between an external loader stream and the instruction memory of the microprocessor top. It accepts instruction words over a valid/ready stream and writes them to consecutive word addresses. It holds the core in reset throughout the load and checks a running checksum against an expected value. It releases the core only after a configurable hold period on a successful load.

---
 rtl/boot_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//
// Program-load controller between an external loader stream and the
// instruction memory. Words arriving on a valid/ready stream are written to
// consecutive word addresses starting at 0 while the core is held in reset.
// A running checksum (sum of all words, modulo 2^DATA_WIDTH) is compared with
// the expected value captured at start. On a match the core is released after
// HOLD_CYCLES cycles. A checksum mismatch, or a stream that runs past the
// last address, parks the controller in an error state.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   start         begin a load (taken in IDLE, RUN and ERR only)
//   expected_sum  expected checksum, captured when start is taken
//   load_valid    stream word valid
//   load_data     stream word
//   load_last     final word marker, qualified by an accepted beat
//   load_ready    controller can accept a word (decoded from state only)
//   imem_we       instruction-memory write enable (= accepted beat)
//   imem_addr     instruction-memory word address (write pointer)
//   imem_wdata    instruction-memory write data (= load_data)
//   core_rst      registered active-low core reset, 1 only in RUN
//   busy          high in LOAD, CHECK and HOLD
//   done          high in RUN
//   error         high in ERR
//   err_code      00 none, 01 overflow, 10 checksum mismatch
//   word_count    words written in the current or last load
// ---------------------------------------------------------------------------
module boot_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] expected_sum,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [1:0]            r_err_code;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic                  r_core_rst;

    logic w_accept;
    logic w_overflow;
    logic w_enter_load;

    // Ready depends on state only, so there is no path from load_valid.
    assign load_ready = (r_state == S_LOAD);
    assign w_accept   = load_valid & load_ready;
    // A non-last beat at the final address is still written, then we stop.
    assign w_overflow = w_accept & ~load_last & (r_wptr == LAST_ADDR);

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD: begin
                if (w_accept && load_last) w_next = S_CHECK;
                else if (w_overflow)       w_next = S_ERR;
            end
            S_CHECK: w_next = (r_sum == r_expected) ? S_HOLD : S_ERR;
            S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_next = S_RUN;
            S_RUN:   if (start) w_next = S_LOAD;
            S_ERR:   if (start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // Covers IDLE, RUN and ERR alike; LOAD never re-enters itself.
    assign w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            r_expected <= '0;
            r_err_code <= ERR_NONE;
            r_hold_cnt <= '0;
            r_core_rst <= 1'b0;
        end else begin
            r_state <= w_next;
            // Registered from the next state so it is 1 exactly while in RUN.
            r_core_rst <= (w_next == S_RUN);

            if (w_enter_load) begin
                r_wptr     <= '0;
                r_count    <= '0;
                r_sum      <= '0;
                r_err_code <= ERR_NONE;
                r_expected <= expected_sum;
            end else if (w_accept) begin
                r_count <= r_count + 1'b1;
                r_sum   <= r_sum + load_data;
                // Saturate: the pointer never wraps back over written words.
                if (r_wptr != LAST_ADDR) r_wptr <= r_wptr + 1'b1;
            end

            if (w_overflow)
                r_err_code <= ERR_OVERFLOW;
            else if (r_state == S_CHECK && r_sum != r_expected)
                r_err_code <= ERR_CHECKSUM;

            if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
            else                   r_hold_cnt <= '0;
        end
    end

    assign imem_we    = w_accept;
    assign imem_addr  = r_wptr;
    assign imem_wdata = load_data;
    assign core_rst   = r_core_rst;
    assign busy       = (r_state == S_LOAD) || (r_state == S_CHECK) || (r_state == S_HOLD);
    assign done       = (r_state == S_RUN);
    assign error      = (r_state == S_ERR);
    assign err_code   = r_err_code;
    assign word_count = r_count;

endmodule
